gmii_rx_frame: RTL and testbench
================================

# gmii_rx_frame

Receive-side Ethernet frame delineator that sits directly downstream of the RGMII-to-GMII receive converter in the `gmii_rx_clk` domain. It consumes the 8-bit GMII byte stream and finds preamble/SFD. It emits the frame bytes (destination MAC through FCS) as a marked stream with start/end flags, and qualifies each frame by CRC-32 and length. Its output feeds the MAC/UDP receive logic.

## Interface
Parameters:
- `MIN_LEN`, 64 — minimum legal frame length in bytes, FCS included.
- `MAX_LEN`, 1518 — maximum legal frame length in bytes, FCS included; must be < 2047.
- `LOCAL_MAC`, 48'h00_11_22_33_44_55 — unicast address accepted by the filter; sent first byte = bits [47:40].

Ports:
- `clk` in 1 — GMII receive clock (driven by `gmii_rx_clk`, 125 MHz).
- `rst_n` in 1 — asynchronous, active-low reset.
- `gmii_rx_dv` in 1 — GMII receive data valid.
- `gmii_rxd` in 8 — GMII receive byte.
- `rx_data` out 8 — frame byte.
- `rx_valid` out 1 — `rx_data` valid this cycle.
- `rx_sop` out 1 — first byte of frame; qualified by `rx_valid`.
- `rx_eop` out 1 — last byte of frame; qualified by `rx_valid`.
- `rx_good` out 1 — frame accepted; pulses only with `rx_eop`.
- `rx_bad` out 1 — frame rejected; pulses only with `rx_eop`.
- `rx_len` out 11 — byte count of the frame incl. FCS; valid with `rx_eop`.
- `err_cnt` out 16 — saturating count of `rx_bad` pulses.

## Operation
- States:
  - IDLE: `dv`=1 and byte 0x55 → PRE with preamble count 1. `dv`=1 with any other byte → DROP.
  - PRE: 0x55 → increment count, saturating at 7. 0xD5 → DATA. Any other byte → DROP. `dv`=0 → IDLE, nothing emitted.
  - DATA: each byte with `dv`=1 enters a one-byte hold register; the previously held byte moves to the output with `eop`=0. On `dv`=0 the held byte is output with `eop`=1 and the state returns to IDLE.
  - DROP: wait for `dv`=0 → IDLE.
- `rx_sop` is set on the first DATA byte.
- CRC-32 uses the reflected polynomial 0xEDB88320, initialised to 0xFFFFFFFF, updated with every DATA byte including the FCS. At end of frame, a register value of 0xDEBB20E3 means the CRC is OK.
- The length counter is 11-bit and counts DATA bytes.
  - When byte `MAX_LEN`+1 arrives, that byte is not emitted. The held byte is output with `eop`+`rx_bad`, `rx_len`=`MAX_LEN`, and the state → DROP.
- At normal end of frame:
  - `rx_good` = CRC OK and `MIN_LEN` ≤ len ≤ `MAX_LEN`.
  - `rx_bad` = the inverse of `rx_good`.
  - `rx_good` and `rx_bad` are never asserted together.
- `err_cnt` increments on each `rx_bad` pulse and holds at 0xFFFF.
- Zero-byte frame (SFD immediately followed by `dv`=0): nothing is emitted and no counter changes.
- Back-to-back frames: one `dv`=0 cycle between frames is sufficient. The eop output and the new preamble may overlap.
- Reset mid-frame: all outputs and state clear immediately. If `dv` is still high after release, the current byte is not 0x55-led from IDLE in normal traffic, so the remainder of the frame is consumed in DROP.

## Timing
- Reset values: `rx_data`=0x00, `rx_valid`=`rx_sop`=`rx_eop`=`rx_good`=`rx_bad`=0, `rx_len`=0, `err_cnt`=0; state IDLE; CRC register 0xFFFFFFFF.
- Latency: a byte on `gmii_rxd` in cycle c appears on `rx_data` in cycle c+2.
- The eop byte appears in the cycle after the first `dv`=0 cycle.
- `rx_valid` is asserted on consecutive cycles across a frame, with no gaps. There is no backpressure.
- `rx_sop` and `rx_eop` may both be asserted on a 1-byte frame.
- All outputs are registered.

## Configuration
- `RX_MAC_FILTER_EN` defined:
  - Destination bytes 1–6 are compared against `LOCAL_MAC` and FF:FF:FF:FF:FF:FF.
  - On mismatch, detected when byte 6 is sampled, byte 6 is output flagged `eop`+`rx_bad`, `rx_len`=6, and the state → DROP.
  - Filter rejects do NOT increment `err_cnt`.
- `RX_MAC_FILTER_EN` undefined: there is no address check and all frames pass through.

## Test plan
- 7×0x55, 0xD5, then a 64-byte broadcast frame with correct FCS from the bench model → 64 bytes out, sop on byte 1, eop on byte 64 with `rx_good`=1, `rx_len`=64, `err_cnt`=0.
- The same frame with FCS bit 0 flipped → eop with `rx_bad`=1, `rx_len`=64, `err_cnt`=1.
- A valid-CRC 60-byte runt → `rx_bad`=1, `rx_len`=60. A 1600-byte frame → eop on byte 1518 with `rx_bad`, no further `rx_valid` until the next frame.
- Preamble corrupted to 0x55,0x57 → no `rx_valid` for the frame. Then, after 1 idle cycle, a good 64-byte frame → `rx_good`=1.
- `rst_n` pulsed low for 1 cycle at byte 20 of a frame → outputs 0 during reset, no eop for that frame, and the next good frame is received normally.
- With `RX_MAC_FILTER_EN`, destination 00:11:22:33:44:56 → eop on byte 6, `rx_bad`=1, `rx_len`=6, `err_cnt` unchanged. Destination = `LOCAL_MAC` → `rx_good`.

Source files
------------

// File: rtl/gmii_rx_frame.sv
// ---------------------------------------------------------------------------
// gmii_rx_frame
//
// Receive-side Ethernet frame delineator in the gmii_rx_clk domain. Finds
// preamble/SFD in the GMII byte stream and emits the frame bytes (destination
// MAC through FCS) as a marked stream. Each frame is qualified by CRC-32 and
// length at its last byte.
//
// Optional feature: define RX_MAC_FILTER_EN to enable the destination
// address filter (LOCAL_MAC unicast or broadcast accepted). Filter rejects
// end the frame at byte 6 with rx_bad but do not count in err_cnt.
//
// Ports:
//   clk        in   GMII receive clock (125 MHz)
//   rst_n      in   asynchronous active-low reset
//   gmii_rx_dv in   GMII receive data valid
//   gmii_rxd   in   GMII receive byte
//   rx_data    out  frame byte
//   rx_valid   out  rx_data valid this cycle
//   rx_sop     out  first byte of frame (qualified by rx_valid)
//   rx_eop     out  last byte of frame (qualified by rx_valid)
//   rx_good    out  frame accepted, only with rx_eop
//   rx_bad     out  frame rejected, only with rx_eop
//   rx_len     out  frame byte count incl. FCS, valid with rx_eop
//   err_cnt    out  saturating count of counted rx_bad pulses
// ---------------------------------------------------------------------------
module gmii_rx_frame #(
    parameter int          MIN_LEN   = 64,
    parameter int          MAX_LEN   = 1518,
    parameter logic [47:0] LOCAL_MAC = 48'h00_11_22_33_44_55
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sop,
    output logic        rx_eop,
    output logic        rx_good,
    output logic        rx_bad,
    output logic [10:0] rx_len,
    output logic [15:0] err_cnt
);

`ifdef RX_MAC_FILTER_EN
    localparam logic FILTER_EN = 1'b1;
`else
    localparam logic FILTER_EN = 1'b0;
`endif

    localparam logic [10:0] MIN_L       = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L       = 11'(MAX_LEN);
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_DROP
    } state_t;

    // Reflected CRC-32 (0xEDB88320), one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t      state_q;
    logic [2:0]  pre_cnt_q;
    logic [7:0]  hold_q;
    logic [10:0] len_q;
    logic [31:0] crc_q;
    logic [31:0] crc_d;
    logic        uc_ok_q;
    logic        bc_ok_q;
    logic        flt_rej_q;

    logic [7:0]  rx_data_q;
    logic        rx_valid_q;
    logic        rx_sop_q;
    logic        rx_eop_q;
    logic        rx_good_q;
    logic        rx_bad_q;
    logic [10:0] rx_len_q;
    logic [15:0] err_cnt_q;

    logic [7:0]  mac_byte;
    logic        uc_hit;
    logic        bc_hit;
    logic        flt_reject;
    logic        frame_ok;

    assign crc_d = crc32_byte(crc_q, gmii_rxd);

    // Expected LOCAL_MAC byte for the destination byte arriving now
    // (len_q = number of bytes already taken).
    always_comb begin
        mac_byte = 8'h00;
        case (len_q)
            11'd0:   mac_byte = LOCAL_MAC[47:40];
            11'd1:   mac_byte = LOCAL_MAC[39:32];
            11'd2:   mac_byte = LOCAL_MAC[31:24];
            11'd3:   mac_byte = LOCAL_MAC[23:16];
            11'd4:   mac_byte = LOCAL_MAC[15:8];
            11'd5:   mac_byte = LOCAL_MAC[7:0];
            default: mac_byte = 8'h00;
        endcase
    end

    // Running match flags include the current byte; the decision is taken
    // as byte 6 is sampled.
    assign uc_hit     = uc_ok_q && (gmii_rxd == mac_byte);
    assign bc_hit     = bc_ok_q && (gmii_rxd == 8'hFF);
    assign flt_reject = FILTER_EN && (len_q == 11'd5) && !uc_hit && !bc_hit;

    // crc_q and len_q already include every byte of the frame when dv drops.
    assign frame_ok = (crc_q == CRC_RESIDUE) && (len_q >= MIN_L) && (len_q <= MAX_L);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pre_cnt_q  <= 3'd0;
            hold_q     <= 8'h00;
            len_q      <= 11'd0;
            crc_q      <= 32'hFFFFFFFF;
            uc_ok_q    <= 1'b0;
            bc_ok_q    <= 1'b0;
            flt_rej_q  <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_sop_q   <= 1'b0;
            rx_eop_q   <= 1'b0;
            rx_good_q  <= 1'b0;
            rx_bad_q   <= 1'b0;
            rx_len_q   <= 11'd0;
            err_cnt_q  <= 16'd0;
        end else begin
            // Flags are single-cycle pulses unless set below.
            rx_valid_q <= 1'b0;
            rx_sop_q   <= 1'b0;
            rx_eop_q   <= 1'b0;
            rx_good_q  <= 1'b0;
            rx_bad_q   <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    len_q <= 11'd0;
                    crc_q <= 32'hFFFFFFFF;
                    if (gmii_rx_dv) begin
                        if (gmii_rxd == 8'h55) begin
                            pre_cnt_q <= 3'd1;
                            state_q   <= S_PRE;
                        end else begin
                            state_q <= S_DROP;
                        end
                    end
                end

                S_PRE: begin
                    if (!gmii_rx_dv) begin
                        state_q <= S_IDLE;
                    end else if (gmii_rxd == 8'h55) begin
                        if (pre_cnt_q != 3'd7) pre_cnt_q <= pre_cnt_q + 3'd1;
                    end else if (gmii_rxd == 8'hD5) begin
                        uc_ok_q <= 1'b1;
                        bc_ok_q <= 1'b1;
                        state_q <= S_DATA;
                    end else begin
                        state_q <= S_DROP;
                    end
                end

                S_DATA: begin
                    if (gmii_rx_dv && (len_q == MAX_L)) begin
                        // Oversize: the incoming byte is discarded and the
                        // held byte closes the frame.
                        rx_valid_q <= 1'b1;
                        rx_data_q  <= hold_q;
                        rx_sop_q   <= (len_q == 11'd1);
                        rx_eop_q   <= 1'b1;
                        rx_bad_q   <= 1'b1;
                        rx_len_q   <= MAX_L;
                        err_cnt_q  <= sat_inc16(err_cnt_q);
                        state_q    <= S_DROP;
                    end else if (gmii_rx_dv) begin
                        hold_q  <= gmii_rxd;
                        crc_q   <= crc_d;
                        len_q   <= len_q + 11'd1;
                        uc_ok_q <= uc_hit;
                        bc_ok_q <= bc_hit;
                        if (len_q != 11'd0) begin
                            rx_valid_q <= 1'b1;
                            rx_data_q  <= hold_q;
                            rx_sop_q   <= (len_q == 11'd1);
                        end
                        if (flt_reject) begin
                            // Byte 6 stays in hold_q and is flushed from DROP.
                            flt_rej_q <= 1'b1;
                            state_q   <= S_DROP;
                        end
                    end else begin
                        state_q <= S_IDLE;
                        // An empty frame (SFD then dv low) emits nothing.
                        if (len_q != 11'd0) begin
                            rx_valid_q <= 1'b1;
                            rx_data_q  <= hold_q;
                            rx_sop_q   <= (len_q == 11'd1);
                            rx_eop_q   <= 1'b1;
                            rx_good_q  <= frame_ok;
                            rx_bad_q   <= !frame_ok;
                            rx_len_q   <= len_q;
                            if (!frame_ok) err_cnt_q <= sat_inc16(err_cnt_q);
                        end
                    end
                end

                S_DROP: begin
                    if (flt_rej_q) begin
                        flt_rej_q  <= 1'b0;
                        rx_valid_q <= 1'b1;
                        rx_data_q  <= hold_q;
                        rx_eop_q   <= 1'b1;
                        rx_bad_q   <= 1'b1;
                        rx_len_q   <= len_q;
                    end
                    if (!gmii_rx_dv) state_q <= S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_sop   = rx_sop_q;
    assign rx_eop   = rx_eop_q;
    assign rx_good  = rx_good_q;
    assign rx_bad   = rx_bad_q;
    assign rx_len   = rx_len_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_gmii_rx_frame.sv
`timescale 1ns/1ps
module tb_gmii_rx_frame;

    localparam logic [47:0] MAC     = 48'h00_11_22_33_44_55;
    localparam logic [47:0] BAD_MAC = 48'h00_11_22_33_44_56;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dv = 1'b0;
    logic [7:0]  rxd = 8'h00;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_sop, rx_eop, rx_good, rx_bad;
    logic [10:0] rx_len;
    logic [15:0] err_cnt;

    always #4 clk = ~clk;

    gmii_rx_frame #(.MIN_LEN(64), .MAX_LEN(1518), .LOCAL_MAC(MAC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gmii_rx_dv (dv),
        .gmii_rxd   (rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_sop     (rx_sop),
        .rx_eop     (rx_eop),
        .rx_good    (rx_good),
        .rx_bad     (rx_bad),
        .rx_len     (rx_len),
        .err_cnt    (err_cnt)
    );

    typedef logic [7:0] bq_t[$];

    typedef struct {
        int len;      // bytes on the wire after SFD
        int dest;     // 0 broadcast, 1 LOCAL_MAC, 2 wrong unicast
        bit corrupt;  // flip FCS bit 0
        int exp_out;
        bit exp_good;
        bit exp_bad;
        int exp_len;
        int exp_err;
    } vec_t;

    int n_chk = 0;
    int n_pass = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor (append-only; the test takes snapshots of its counters).
    logic [7:0] cap_data[$];
    bit         cap_sop[$];
    bit         cap_eop[$];
    int n_eop = 0, n_good = 0, n_gap = 0, n_both = 0, n_stray = 0;
    int sop_cyc = 0;
    bit last_good = 0, last_bad = 0;
    int last_len = 0;
    bit in_frame = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 0;
        end else begin
            if (rx_good && rx_bad) n_both++;
            if ((rx_good || rx_bad) && !(rx_valid && rx_eop)) n_stray++;
            if (rx_valid) begin
                cap_data.push_back(rx_data);
                cap_sop.push_back(rx_sop);
                cap_eop.push_back(rx_eop);
                if (rx_sop) begin
                    sop_cyc  = cyc;
                    in_frame = 1;
                end
                if (rx_eop) begin
                    n_eop++;
                    if (rx_good) n_good++;
                    last_good = rx_good;
                    last_bad  = rx_bad;
                    last_len  = int'(rx_len);
                    in_frame  = 0;
                end
            end else if (in_frame) begin
                n_gap++;
                in_frame = 0;
            end
        end
    end

    int b_cap, b_eop, b_good, first_cyc;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic snap();
        b_cap  = cap_data.size();
        b_eop  = n_eop;
        b_good = n_good;
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic build_frame(input int len, input int dest, input bit corrupt, output bq_t f);
        logic [47:0] da;
        logic [31:0] crc;
        da = (dest == 0) ? 48'hFFFF_FFFF_FFFF : (dest == 1) ? MAC : BAD_MAC;
        f = {};
        for (int i = 0; i < len; i++) begin
            if (i < 6) f.push_back(da[47 - 8*i -: 8]);
            else       f.push_back(8'(i));
        end
        if (len > 4) begin
            crc = 32'hFFFFFFFF;
            for (int i = 0; i < len - 4; i++) crc = crc_upd(crc, f[i]);
            crc = ~crc;
            f[len-4] = crc[7:0];
            f[len-3] = crc[15:8];
            f[len-2] = crc[23:16];
            f[len-1] = crc[31:24];
            if (corrupt) f[len-4] = f[len-4] ^ 8'h01;
        end
    endtask

    task automatic add_pre(input bq_t f, output bq_t o);
        o = {};
        for (int i = 0; i < 7; i++) o.push_back(8'h55);
        o.push_back(8'hD5);
        for (int i = 0; i < f.size(); i++) o.push_back(f[i]);
    endtask

    task automatic send(input bq_t bytes, input int gap, input int first_idx);
        for (int i = 0; i < bytes.size(); i++) begin
            @(negedge clk);
            dv  = 1'b1;
            rxd = bytes[i];
            if (i == first_idx) first_cyc = cyc;
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            dv  = 1'b0;
            rxd = 8'h00;
        end
    endtask

    task automatic check_frame(input string nm, input bq_t f, input vec_t v);
        int n, mism, nsop;
        repeat (3) @(negedge clk);
        n = cap_data.size() - b_cap;
        chk({nm, " bytes"}, n, v.exp_out);
        mism = 0;
        nsop = 0;
        for (int i = 0; i < n; i++) begin
            if (i < v.exp_out && i < f.size() && cap_data[b_cap+i] !== f[i]) mism++;
            if (cap_sop[b_cap+i]) nsop++;
        end
        chk({nm, " data_mismatches"}, mism, 0);
        if (n > 0) begin
            chk({nm, " sop_first"}, int'(cap_sop[b_cap]), 1);
            chk({nm, " sop_count"}, nsop, 1);
            chk({nm, " eop_last"}, int'(cap_eop[b_cap+n-1]), 1);
            chk({nm, " latency"}, sop_cyc - first_cyc, 2);
        end
        chk({nm, " eop_count"}, n_eop - b_eop, 1);
        chk({nm, " good"}, int'(last_good), int'(v.exp_good));
        chk({nm, " bad"}, int'(last_bad), int'(v.exp_bad));
        chk({nm, " len"}, last_len, v.exp_len);
        chk({nm, " err_cnt"}, int'(err_cnt), v.exp_err);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        vec_t good64;
        bq_t  f, full;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst rx_valid", int'(rx_valid), 0);
        chk("rst rx_sop",   int'(rx_sop),   0);
        chk("rst rx_eop",   int'(rx_eop),   0);
        chk("rst rx_good",  int'(rx_good),  0);
        chk("rst rx_bad",   int'(rx_bad),   0);
        chk("rst rx_data",  int'(rx_data),  0);
        chk("rst rx_len",   int'(rx_len),   0);
        chk("rst err_cnt",  int'(err_cnt),  0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        //                len  dst cor out  good bad len  err
        vecs.push_back('{  64, 0, 0,   64, 1, 0,   64, 0});
        vecs.push_back('{  64, 0, 1,   64, 0, 1,   64, 1});
        vecs.push_back('{  60, 0, 0,   60, 0, 1,   60, 2});
        vecs.push_back('{1600, 0, 0, 1518, 0, 1, 1518, 3});
        vecs.push_back('{  64, 1, 0,   64, 1, 0,   64, 3});
        vecs.push_back('{1518, 0, 0, 1518, 1, 0, 1518, 3});
        vecs.push_back('{   1, 0, 0,    1, 0, 1,    1, 4});
        vecs.push_back('{  65, 1, 0,   65, 1, 0,   65, 4});
`ifdef RX_MAC_FILTER_EN
        vecs.push_back('{  64, 2, 0,    6, 0, 1,    6, 4});
`endif

        foreach (vecs[i]) begin
            build_frame(vecs[i].len, vecs[i].dest, vecs[i].corrupt, f);
            add_pre(f, full);
            snap();
            send(full, 4, 8);
            check_frame($sformatf("vec%0d", i), f, vecs[i]);
        end

        good64 = '{64, 0, 0, 64, 1, 0, 64, 4};
        build_frame(64, 0, 0, f);

        // Zero-byte frame: SFD then dv low.
        full = {8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5};
        snap();
        send(full, 3, -1);
        repeat (2) @(negedge clk);
        chk("zero bytes",   cap_data.size() - b_cap, 0);
        chk("zero eop",     n_eop - b_eop, 0);
        chk("zero err_cnt", int'(err_cnt), 4);

        // Corrupted preamble, one idle cycle, then a good frame.
        full = {8'h55, 8'h57, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5};
        for (int i = 0; i < f.size(); i++) full.push_back(f[i]);
        snap();
        send(full, 1, -1);
        add_pre(f, full);
        send(full, 4, 8);
        check_frame("badpre", f, good64);

        // Back-to-back frames with a single idle cycle.
        snap();
        send(full, 1, 8);
        send(full, 4, 8);
        repeat (3) @(negedge clk);
        chk("b2b bytes", cap_data.size() - b_cap, 128);
        chk("b2b eop",   n_eop - b_eop, 2);
        chk("b2b good",  n_good - b_good, 2);

        // Reset pulse at frame byte 20.
        snap();
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            dv  = 1'b1;
            rxd = full[i];
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst rx_valid", int'(rx_valid), 0);
        chk("midrst rx_data",  int'(rx_data),  0);
        chk("midrst rx_len",   int'(rx_len),   0);
        chk("midrst err_cnt",  int'(err_cnt),  0);
        @(negedge clk);
        rxd = full[28];
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 29; i < full.size(); i++) begin
            @(negedge clk);
            dv  = 1'b1;
            rxd = full[i];
        end
        for (int g = 0; g < 4; g++) begin
            @(negedge clk);
            dv  = 1'b0;
            rxd = 8'h00;
        end
        repeat (3) @(negedge clk);
        chk("midrst eop", n_eop - b_eop, 0);
        good64.exp_err = 0;
        snap();
        send(full, 4, 8);
        check_frame("afterrst", f, good64);

        chk("inv valid_gaps",  n_gap, 0);
        chk("inv good_and_bad", n_both, 0);
        chk("inv flag_without_eop", n_stray, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
